// File: rtl/sqrt_post_pkg.sv
// sqrt_post_pkg: state encoding, widths and default CORDIC gain shared by the sqrt post-processor.
package sqrt_post_pkg;
  localparam int DATA_W = 32;
  localparam int ROOT_W = 16;
  localparam int EXP_W = 5;
  localparam int MAX_EXP = 15;
  localparam logic [DATA_W-1:0] GAIN_INV_DEF = 32'd1296543253;
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
endpackage

// File: rtl/sqrt_post_if.sv
// sqrt_post_if: operand/result handshake between the CORDIC stage and the root consumer.
interface sqrt_post_if
  import sqrt_post_pkg::*;
();
  logic i_en;
  logic [DATA_W-1:0] ix;
  logic [EXP_W-1:0] i_exp;
  logic o_valid;
  logic o_ready;
  logic [ROOT_W-1:0] o_root;
  logic o_busy;
  logic o_drop;
  modport master (output i_en, ix, i_exp, o_ready, input o_valid, o_root, o_busy, o_drop);
  modport slave (input i_en, ix, i_exp, o_ready, output o_valid, o_root, o_busy, o_drop);
endinterface

// File: rtl/sqrt_post_mul.sv
// seq_mul_u32: unsigned 32x32 shift-add multiplier, one multiplier bit per cycle, done after 32 cycles.
module seq_mul_u32
  import sqrt_post_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic done,
  output logic [2*DATA_W-1:0] p
);
  logic [2*DATA_W-1:0] mcand, acc;
  logic [DATA_W-1:0] mplier;
  logic [5:0] cnt;
  logic run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      mcand <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == 6'd32) run <= 1'b0;
      else begin
        acc <= acc + (mplier[0] ? mcand : '0);
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 6'd1;
      end
    end
  assign done = run && cnt == 6'd32;
  assign p = acc;
endmodule

// File: rtl/sqrt_post.sv
// sqrt_post: scales the CORDIC x result by the inverse gain, denormalizes, rounds and saturates to a 16-bit root.
module sqrt_post
  import sqrt_post_pkg::*;
#(
  parameter logic [DATA_W-1:0] GAIN_INV = GAIN_INV_DEF
) (
  input logic clk,
  input logic rst_n,
  sqrt_post_if.slave bus
);
  state_t state, state_n;
  logic start, done, zero_q, drop_q;
  logic [3:0] exp_q;
  logic [2*DATA_W-1:0] p;
  logic [2*DATA_W:0] sum, shifted;
  logic [ROOT_W-1:0] root_c, root_q;
  seq_mul_u32 u_mul (.clk(clk), .rst_n(rst_n), .start(start), .a(bus.ix), .b(GAIN_INV), .done(done), .p(p));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.i_en) state_n = MUL;
    else if (state == MUL && done) state_n = OUT;
    else if (state == OUT && bus.o_ready) state_n = IDLE;
  end
  always_comb begin
    start = state == IDLE && bus.i_en;
    bus.o_busy = state != IDLE;
    bus.o_valid = state == OUT;
    bus.o_root = state == OUT ? root_q : '0;
    bus.o_drop = drop_q;
  end
  // 65-bit sum keeps the rounding constant from overflowing a near-full product
  always_comb begin
    sum = {1'b0, p} + ((2*DATA_W+1)'(1) << (7'd43 + {3'b0, exp_q}));
    shifted = sum >> (7'd44 + {3'b0, exp_q});
    root_c = zero_q ? '0 : (|shifted[2*DATA_W:ROOT_W] ? '1 : shifted[ROOT_W-1:0]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_q <= '0;
      zero_q <= 1'b0;
      root_q <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= bus.i_en && state != IDLE;
      if (start) begin
        exp_q <= bus.i_exp[3:0];
        zero_q <= bus.ix[DATA_W-1] || bus.i_exp > EXP_W'(MAX_EXP);
      end
      if (state == MUL && done) root_q <= root_c;
    end
endmodule

// File: tb/tb_sqrt_post.sv
// tb_sqrt_post: directed checks of latency, rounding, saturation, drops, backpressure and reset for sqrt_post.
module tb_sqrt_post;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ready = 1'b1, sel = 1'b0;
  logic [31:0] ix_s = '0;
  logic [4:0] exp_s = '0;
  int checks = 0, errors = 0;
  logic vld, busy, drop;
  logic [15:0] root;
  sqrt_post_if if_u ();
  sqrt_post_if if_d ();
  assign if_u.i_en = en;
  assign if_u.ix = ix_s;
  assign if_u.i_exp = exp_s;
  assign if_u.o_ready = ready;
  assign if_d.i_en = en;
  assign if_d.ix = ix_s;
  assign if_d.i_exp = exp_s;
  assign if_d.o_ready = ready;
  sqrt_post #(.GAIN_INV(32'h4000_0000)) u_unity (.clk(clk), .rst_n(rst_n), .bus(if_u));
  sqrt_post u_def (.clk(clk), .rst_n(rst_n), .bus(if_d));
  assign vld = sel ? if_d.o_valid : if_u.o_valid;
  assign busy = sel ? if_d.o_busy : if_u.o_busy;
  assign drop = sel ? if_d.o_drop : if_u.o_drop;
  assign root = sel ? if_d.o_root : if_u.o_root;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [4:0] e, input logic [15:0] r, input string tag);
    int n;
    ix_s = a;
    exp_s = e;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    n = 0;
    while (!vld && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_root"}, {16'h0, root}, {16'h0, r});
    if (ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_vld_after"}, {31'h0, vld}, 0);
      chk({tag, "_root_after"}, {16'h0, root}, 0);
    end
  endtask

  initial begin
    int rises, seen;
    logic prev;
    repeat (3) @(negedge clk);
    chk("rst_vld_u", {31'h0, if_u.o_valid}, 0);
    chk("rst_root_u", {16'h0, if_u.o_root}, 0);
    chk("rst_busy_d", {31'h0, if_d.o_busy}, 0);
    chk("rst_drop_d", {31'h0, if_d.o_drop}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h2000_0000, 5'd0, 16'd32768, "s1");
    run(32'h2000_2000, 5'd0, 16'd32769, "half_up");
    run(32'h2000_1FFF, 5'd0, 16'd32768, "below_half");
    run(32'h2000_0000, 5'd3, 16'd4096, "s2_k3");
    run(32'h4000_0000, 5'd0, 16'hFFFF, "s2_sat");
    run(32'h4000_0000, 5'd15, 16'd2, "k15");
    run(32'h8000_0000, 5'd0, 16'd0, "s3_neg");
    run(32'h2000_0000, 5'd16, 16'd0, "s3_exp16");
    sel = 1'b1;
    ready = 1'b0;
    run(32'h2000_0000, 5'd0, 16'd39567, "s4");
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("s4_hold_vld", {31'h0, vld}, 1);
      chk("s4_hold_root", {16'h0, root}, 39567);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("s4_vld_after", {31'h0, vld}, 0);
    chk("s4_busy_after", {31'h0, busy}, 0);
    ready = 1'b0;
    ix_s = 32'h1000_0000;
    exp_s = 5'd1;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      en = (e == 10 || e == 40 || e == 44);
      ready = (e == 44);
      if (en) begin
        ix_s = 32'hFFFF_FFFF;
        exp_s = 5'd0;
      end
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      chk("s5_drop", {31'h0, drop}, (e == 10 || e == 40 || e == 44) ? 1 : 0);
      if (vld && !prev) rises++;
      prev = vld;
      if (e == 33) chk("s5_root", {16'h0, root}, 9892);
      if (e == 43) chk("s5_root_held", {16'h0, root}, 9892);
    end
    chk("s5_one_valid", rises, 1);
    chk("s5_idle_busy", {31'h0, busy}, 0);
    chk("s5_idle_vld", {31'h0, vld}, 0);
    ready = 1'b1;
    ix_s = 32'h3000_0000;
    exp_s = 5'd0;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("s6_mid_busy", {31'h0, busy}, 1);
    chk("s6_mid_root", {16'h0, root}, 0);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", {31'h0, busy}, 0);
    chk("s6_rst_vld", {31'h0, vld}, 0);
    chk("s6_rst_drop", {31'h0, drop}, 0);
    chk("s6_rst_root", {16'h0, root}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vld || busy) seen++;
    end
    chk("s6_quiet", seen, 0);
    run(32'h3000_0000, 5'd0, 16'd59351, "s6_fresh");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqrt_post.md
SQRT_POST -- requirements
Module: sqrt_post

Interface
REQ-001 Parameter GAIN_INV, default 32'd1296543253, is the unsigned Q2.30 inverse hyperbolic CORDIC gain (about 1.2075).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_en  input  1  one-cycle pulse; CORDIC x result and exponent are valid.
REQ-005 ix  input  32  CORDIC x output, signed Q2.30.
REQ-006 i_exp  input  5  normalization shift k from the pre-normalizer; the operand satisfies a_n = a*2^(2k)/2^32; values above 15 encode a == 0.
REQ-007 o_valid  output  1  o_root is valid; held until accepted.
REQ-008 o_ready  input  1  downstream accept.
REQ-009 o_root  output  16  unsigned integer square root.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_drop  output  1  one-cycle pulse: an i_en was ignored.

Function
REQ-012 The FSM SHALL have three states: IDLE, MUL, OUT.
REQ-013 IDLE + i_en SHALL capture ix, i_exp and GAIN_INV, clear the 64-bit accumulator and a 6-bit counter, and go to MUL.
REQ-014 MUL SHALL be an unsigned shift-add multiply, one multiplier bit per cycle, exactly 32 cycles, then go to OUT.
REQ-015 If captured ix[31]=1 (negative) or i_exp>15, the result SHALL be forced to 0; the 32 MUL cycles SHALL still run, so latency is fixed.
REQ-016 Product P = ix*GAIN_INV SHALL be 64 bits unsigned in Q4.60.
REQ-017 Root SHALL be (P + 2^(43+k)) >> (44+k), i.e. round-half-up, computed without overflow (65-bit sum).
REQ-018 A root above 65535 SHALL saturate to 16'hFFFF.
REQ-019 o_valid SHALL rise on the 33rd rising edge after the edge that sampled i_en.
REQ-020 In OUT, o_valid and o_root SHALL stay stable until a cycle with o_ready=1; that edge SHALL return the FSM to IDLE and drop o_valid.
REQ-021 o_root SHALL read 0 whenever o_valid=0.
REQ-022 An i_en in MUL or OUT SHALL be ignored, SHALL raise o_drop for one cycle, and SHALL leave the in-flight result unchanged.
REQ-023 An i_en in the same cycle as an OUT-state handshake SHALL be dropped: there is no back-to-back acceptance.

Reset
REQ-024 Reset SHALL give state=IDLE, o_valid=0, o_root=0, o_busy=0, o_drop=0, counter=0, accumulator=0.
REQ-025 Reset asserted mid-MUL or in OUT SHALL discard the operation; after release, the block SHALL produce no output until a new i_en.

Structure
REQ-026 A shared package SHALL hold the state encoding, the default GAIN_INV, the shared width constants (DATA_W=32, ROOT_W=16, EXP_W=5) and MAX_EXP=15.
REQ-027 The shift-add multiplier SHALL be one sub-module, seq_mul_u32 (start/done, 32-cycle).
REQ-028 Rounding, denormalization shift and saturation SHALL be combinational logic in sqrt_post, registered into o_root on entry to OUT.

Verification
REQ-029 Scenarios 1-3 override GAIN_INV=2^30 (unity); scenarios 4-6 use the default.
REQ-030 Scenario 1: ix=2^29, i_exp=0, o_ready=1 -> o_root=32768, o_valid on edge 33.
REQ-031 Scenario 2: ix=2^29, i_exp=3 -> o_root=4096; ix=2^30, i_exp=0 -> saturates to 65535.
REQ-032 Scenario 3: ix=32'h8000_0000 -> o_root=0; i_exp=16 -> o_root=0; both with latency 33.
REQ-033 Scenario 4: o_ready held low 5 cycles after o_valid -> o_root stable for 6 cycles; handshake on the 6th; o_valid=0 the next cycle.
REQ-034 Scenario 5: i_en pulsed at edges 10 and 40 during one operation -> two o_drop pulses; first result correct; exactly one o_valid.
REQ-035 Scenario 6: rst_n low at MUL cycle 20 -> all outputs 0; no o_valid until a fresh i_en, which then completes in 33 cycles.
